// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN,
    MD_BUSY
  } md_state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0020;

  // A producer only counts when it writes a real register ($0 is never forwarded).
  function automatic logic reg_hit(input logic regwrite, input logic [4:0] wreg,
                                   input logic [4:0] src);
    return regwrite && (wreg != 5'd0) && (wreg == src);
  endfunction

  function automatic fwd_sel_t fwd_select(input logic [4:0] src,
                                          input logic regwrite_m, input logic [4:0] wreg_m,
                                          input logic regwrite_w, input logic [4:0] wreg_w);
    if (reg_hit(regwrite_m, wreg_m, src)) return FWD_MEM;
    if (reg_hit(regwrite_w, wreg_w, src)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/ctrl_bus_if.sv
// Clock and synchronous reset bundle shared by the pipeline control blocks.
interface ctrl_bus_if;
  logic clk;
  logic reset;

  modport central (input clk, input reset);
endinterface

// File: rtl/hazard_ctrl_md_timer.sv
// Busy tracker for the multi-cycle multiply/divide unit: FSM plus down-counter.
module md_timer
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32,
  parameter int CW       = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  md_state_t     state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] load_val;

  assign load_val = is_div ? CW'(DIV_LAT - 1) : CW'(MULT_LAT - 1);

  // A start while already busy restarts the count with the new latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (start) begin
            state <= MD_BUSY;
            cnt   <= load_val;
            busy  <= 1'b1;
          end
        end
        MD_BUSY: begin
          if (start) begin
            cnt <= load_val;
          end else if (cnt == '0) begin
            state <= RUN;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding selects, stalls,
// flushes and mult/div hold-off for HI/LO consumers.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32,
  parameter int CW       = 6
) (
  ctrl_bus_if.central ctrl_bus,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic        branch_d,
  input  logic        jump_d,
  input  logic        pc_src_d,
  input  logic        hilo_use_d,
  input  logic [4:0]  rs_e,
  input  logic [4:0]  rt_e,
  input  logic [4:0]  wreg_e,
  input  logic        regwrite_e,
  input  logic        memtoreg_e,
  input  logic        md_start_e,
  input  logic        md_is_div_e,
  input  logic [4:0]  wreg_m,
  input  logic [4:0]  wreg_w,
  input  logic        regwrite_m,
  input  logic        memtoreg_m,
  input  logic        regwrite_w,
  input  logic        imem_ready,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_d,
  output logic        flush_e,
  output logic        fwd_a_d,
  output logic        fwd_b_d,
  output logic [1:0]  fwd_a_e,
  output logic [1:0]  fwd_b_e,
  output logic        md_busy
);

  logic md_busy_q;
  logic lw_stall;
  logic br_stall;
  logic md_stall;
  logic stall;

  md_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CW       (CW)
  ) u_md_timer (
    .clk    (ctrl_bus.clk),
    .reset  (ctrl_bus.reset),
    .start  (md_start_e),
    .is_div (md_is_div_e),
    .busy   (md_busy_q)
  );

  always_comb begin
    lw_stall = memtoreg_e && (wreg_e != 5'd0) && ((wreg_e == rs_d) || (wreg_e == rt_d));
    // A branch compares in D, so it must also wait on a load still sitting in M.
    br_stall = branch_d &&
               (reg_hit(regwrite_e, wreg_e, rs_d) || reg_hit(regwrite_e, wreg_e, rt_d) ||
                reg_hit(memtoreg_m, wreg_m, rs_d) || reg_hit(memtoreg_m, wreg_m, rt_d));
    md_stall = hilo_use_d && md_busy_q;
    stall    = lw_stall || br_stall || md_stall;
  end

  // Everything is held at zero while reset is asserted, including md_busy.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    fwd_a_d = 1'b0;
    fwd_b_d = 1'b0;
    fwd_a_e = FWD_RF;
    fwd_b_e = FWD_RF;
    md_busy = 1'b0;
    if (!ctrl_bus.reset) begin
      stall_f = stall || !imem_ready;
      stall_d = stall;
      flush_e = stall;
      flush_d = (pc_src_d || jump_d || !imem_ready) && !stall;
      fwd_a_d = reg_hit(regwrite_m, wreg_m, rs_d);
      fwd_b_d = reg_hit(regwrite_m, wreg_m, rt_d);
      fwd_a_e = fwd_select(rs_e, regwrite_m, wreg_m, regwrite_w, wreg_w);
      fwd_b_e = fwd_select(rt_e, regwrite_m, wreg_m, regwrite_w, wreg_w);
      md_busy = md_busy_q;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: constant vector table, hand-written
// mult/div/reset/fetch sequences, and randomized cycles against a reference model.
module tb_hazard_ctrl;

  localparam int MULT_L = 4;
  localparam int DIV_L  = 32;

  typedef struct packed {
    logic [4:0] rs_d, rt_d;
    logic       branch_d, jump_d, pc_src_d, hilo_use_d;
    logic [4:0] rs_e, rt_e, wreg_e;
    logic       regwrite_e, memtoreg_e, md_start_e, md_is_div_e;
    logic [4:0] wreg_m, wreg_w;
    logic       regwrite_m, memtoreg_m, regwrite_w, imem_ready;
  } in_t;

  typedef struct packed {
    logic       stall_f, stall_d, flush_d, flush_e, fwd_a_d, fwd_b_d;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic       md_busy;
  } out_t;

  typedef struct {
    string name;
    in_t   in;
    out_t  exp;
  } vec_t;

  ctrl_bus_if bus();
  in_t  cur;
  logic stall_f, stall_d, flush_d, flush_e, fwd_a_d, fwd_b_d, md_busy;
  logic [1:0] fwd_a_e, fwd_b_e;

  int checks   = 0;
  int failures = 0;
  int edge_no  = 0;
  int busy_end = 0;
  vec_t tbl[$];

  hazard_ctrl dut (
    .ctrl_bus    (bus),
    .rs_d        (cur.rs_d),
    .rt_d        (cur.rt_d),
    .branch_d    (cur.branch_d),
    .jump_d      (cur.jump_d),
    .pc_src_d    (cur.pc_src_d),
    .hilo_use_d  (cur.hilo_use_d),
    .rs_e        (cur.rs_e),
    .rt_e        (cur.rt_e),
    .wreg_e      (cur.wreg_e),
    .regwrite_e  (cur.regwrite_e),
    .memtoreg_e  (cur.memtoreg_e),
    .md_start_e  (cur.md_start_e),
    .md_is_div_e (cur.md_is_div_e),
    .wreg_m      (cur.wreg_m),
    .wreg_w      (cur.wreg_w),
    .regwrite_m  (cur.regwrite_m),
    .memtoreg_m  (cur.memtoreg_m),
    .regwrite_w  (cur.regwrite_w),
    .imem_ready  (cur.imem_ready),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .flush_e     (flush_e),
    .fwd_a_d     (fwd_a_d),
    .fwd_b_d     (fwd_b_d),
    .fwd_a_e     (fwd_a_e),
    .fwd_b_e     (fwd_b_e),
    .md_busy     (md_busy)
  );

  initial bus.clk = 1'b0;
  always #5 bus.clk = ~bus.clk;

  function automatic in_t idle();
    in_t v = '0;
    v.imem_ready = 1'b1;
    return v;
  endfunction

  function automatic out_t mk(input logic sf, sd, fd, fe, ad, bd,
                              input logic [1:0] ae, be, input logic mb);
    out_t o;
    o.stall_f = sf; o.stall_d = sd; o.flush_d = fd; o.flush_e = fe;
    o.fwd_a_d = ad; o.fwd_b_d = bd; o.fwd_a_e = ae; o.fwd_b_e = be; o.md_busy = mb;
    return o;
  endfunction

  function automatic out_t get_act();
    return mk(stall_f, stall_d, flush_d, flush_e, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, md_busy);
  endfunction

  // The unit is busy for L cycles after the issuing edge: edges N .. N+L-1.
  function automatic logic model_busy();
    return edge_no < busy_end;
  endfunction

  function automatic logic writes(input logic we, input logic [4:0] dst, input logic [4:0] src);
    return we && dst != 0 && dst == src;
  endfunction

  function automatic logic [1:0] fwd_ref(input in_t i, input logic [4:0] src);
    if (writes(i.regwrite_m, i.wreg_m, src)) return 2'b10;
    if (writes(i.regwrite_w, i.wreg_w, src)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic out_t model_out(input in_t i, input logic rst, input logic busy);
    logic lw, br, md, st;
    if (rst) return '0;
    lw = i.memtoreg_e && i.wreg_e != 0 && (i.wreg_e == i.rs_d || i.wreg_e == i.rt_d);
    br = i.branch_d && (writes(i.regwrite_e, i.wreg_e, i.rs_d) || writes(i.regwrite_e, i.wreg_e, i.rt_d)
                     || writes(i.memtoreg_m, i.wreg_m, i.rs_d) || writes(i.memtoreg_m, i.wreg_m, i.rt_d));
    md = i.hilo_use_d && busy;
    st = lw || br || md;
    return mk(st || !i.imem_ready, st, (i.pc_src_d || i.jump_d || !i.imem_ready) && !st, st,
              writes(i.regwrite_m, i.wreg_m, i.rs_d), writes(i.regwrite_m, i.wreg_m, i.rt_d),
              fwd_ref(i, i.rs_e), fwd_ref(i, i.rt_e), busy);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_out(input string tag, input out_t a, input out_t e);
    chk({tag, ".stall_f"}, 32'(a.stall_f), 32'(e.stall_f));
    chk({tag, ".stall_d"}, 32'(a.stall_d), 32'(e.stall_d));
    chk({tag, ".flush_d"}, 32'(a.flush_d), 32'(e.flush_d));
    chk({tag, ".flush_e"}, 32'(a.flush_e), 32'(e.flush_e));
    chk({tag, ".fwd_a_d"}, 32'(a.fwd_a_d), 32'(e.fwd_a_d));
    chk({tag, ".fwd_b_d"}, 32'(a.fwd_b_d), 32'(e.fwd_b_d));
    chk({tag, ".fwd_a_e"}, 32'(a.fwd_a_e), 32'(e.fwd_a_e));
    chk({tag, ".fwd_b_e"}, 32'(a.fwd_b_e), 32'(e.fwd_b_e));
    chk({tag, ".md_busy"}, 32'(a.md_busy), 32'(e.md_busy));
  endtask

  // Advance one clock: fold the inputs seen at the edge into the model, then drive new ones.
  task automatic applyStimulus(input in_t v, input logic rst);
    @(posedge bus.clk);
    edge_no++;
    if (bus.reset) busy_end = 0;
    else if (cur.md_start_e) begin
      if (model_busy()) $display("[TB] protocol violation: md_start_e issued while md_busy (cycle %0d)", edge_no);
      busy_end = edge_no + (cur.md_is_div_e ? DIV_L : MULT_L);
    end
    #1;
    cur       = v;
    bus.reset = rst;
    #3;
  endtask

  task automatic checkOutput(input string tag);
    compare_out(tag, get_act(), model_out(cur, bus.reset, model_busy()));
  endtask

  task automatic run_md(input string tag, input logic is_div, input int budget, input int exp_len);
    in_t v = idle();
    int  busy_cnt = 0, stall_cnt = 0;
    v.md_start_e  = 1'b1;
    v.md_is_div_e = is_div;
    v.hilo_use_d  = 1'b1;
    applyStimulus(v, 1'b0);
    checkOutput({tag, "_issue"});
    v.md_start_e = 1'b0;
    for (int k = 0; k < budget; k++) begin
      applyStimulus(v, 1'b0);
      checkOutput(tag);
      if (md_busy) busy_cnt++;
      if (stall_d) stall_cnt++;
    end
    chk({tag, "_busy_len"}, 32'(busy_cnt), 32'(exp_len));
    chk({tag, "_stall_len"}, 32'(stall_cnt), 32'(exp_len));
  endtask

  initial begin
    in_t v;
    int  cnt;

    cur       = idle();
    bus.reset = 1'b1;

    v = idle(); v.wreg_e = 8; v.memtoreg_e = 1; v.regwrite_e = 1; v.rs_d = 8;
    tbl.push_back('{"lw_rs", v, mk(1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0)});
    v = idle(); v.memtoreg_e = 1; v.regwrite_e = 1;
    tbl.push_back('{"lw_r0", v, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0)});
    v = idle(); v.regwrite_m = 1; v.wreg_m = 5; v.regwrite_w = 1; v.wreg_w = 5; v.rs_e = 5;
    tbl.push_back('{"fwd_mem", v, mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0)});
    v.regwrite_m = 0;
    tbl.push_back('{"fwd_wb", v, mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0)});
    v = idle(); v.regwrite_m = 1; v.wreg_m = 7; v.rt_d = 7; v.rt_e = 7;
    tbl.push_back('{"fwd_b_mem", v, mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0)});
    v = idle(); v.regwrite_m = 1; v.regwrite_w = 1;
    tbl.push_back('{"fwd_r0", v, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0)});
    v = idle(); v.pc_src_d = 1; v.branch_d = 1;
    tbl.push_back('{"pc_src", v, mk(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0)});
    v.regwrite_e = 1; v.wreg_e = 3; v.rs_d = 3;
    tbl.push_back('{"pc_src_brstall", v, mk(1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0)});
    v = idle(); v.branch_d = 1; v.memtoreg_m = 1; v.regwrite_m = 1; v.wreg_m = 4; v.rt_d = 4;
    tbl.push_back('{"br_load_m", v, mk(1, 1, 0, 1, 0, 1, 2'b00, 2'b00, 0)});
    v = idle(); v.jump_d = 1;
    tbl.push_back('{"jump", v, mk(0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0)});
    v = idle(); v.imem_ready = 0;
    tbl.push_back('{"imem_wait", v, mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 0)});
    v.wreg_e = 8; v.memtoreg_e = 1; v.regwrite_e = 1; v.rs_d = 8;
    tbl.push_back('{"imem_lw", v, mk(1, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0)});
    v = idle(); v.regwrite_w = 1; v.wreg_w = 9; v.rt_e = 9; v.regwrite_m = 1; v.wreg_m = 10;
    tbl.push_back('{"fwd_b_wb", v, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 0)});

    // Reset with hazards present on the inputs: outputs must all be zero.
    v = idle(); v.pc_src_d = 1; v.imem_ready = 0; v.md_start_e = 1;
    applyStimulus(v, 1'b1);
    compare_out("reset_hold", get_act(), '0);
    applyStimulus(idle(), 1'b1);
    checkOutput("reset_idle");
    applyStimulus(idle(), 1'b0);
    compare_out("post_reset", get_act(), '0);

    foreach (tbl[k]) begin
      applyStimulus(tbl[k].in, 1'b0);
      compare_out(tbl[k].name, get_act(), tbl[k].exp);
    end

    run_md("mult", 1'b0, 12, MULT_L);
    run_md("div", 1'b1, 40, DIV_L);

    // Reset landing in the middle of a divide.
    v = idle(); v.md_start_e = 1; v.md_is_div_e = 1;
    applyStimulus(v, 1'b0);
    v = idle(); v.hilo_use_d = 1;
    for (int k = 0; k < 9; k++) applyStimulus(v, 1'b0);
    checkOutput("div_mid");
    chk("div_mid_busy", 32'(md_busy), 32'd1);
    v.pc_src_d = 1; v.imem_ready = 0;
    applyStimulus(v, 1'b1);
    compare_out("div_reset_hold", get_act(), '0);
    v = idle(); v.hilo_use_d = 1;
    applyStimulus(v, 1'b0);
    chk("div_reset_busy", 32'(md_busy), 32'd0);
    checkOutput("div_reset_after");

    // Fetch not ready for three cycles, then again with a load-use stall.
    v = idle(); v.imem_ready = 0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(v, 1'b0);
      chk("imem_flush_d", 32'(flush_d), 32'd1);
      chk("imem_stall_f", 32'(stall_f), 32'd1);
      checkOutput("imem");
    end
    v.wreg_e = 6; v.memtoreg_e = 1; v.regwrite_e = 1; v.rt_d = 6;
    applyStimulus(v, 1'b0);
    chk("imem_lw_flush_d", 32'(flush_d), 32'd0);
    chk("imem_lw_stall_d", 32'(stall_d), 32'd1);

    // Deliberate reissue while busy: the new latency restarts the count.
    v = idle(); v.md_start_e = 1; v.hilo_use_d = 1;
    applyStimulus(v, 1'b0);
    v.md_start_e = 0;
    applyStimulus(v, 1'b0);
    applyStimulus(v, 1'b0);
    v.md_start_e = 1; v.md_is_div_e = 1;
    applyStimulus(v, 1'b0);
    v.md_start_e = 0; v.md_is_div_e = 0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      applyStimulus(v, 1'b0);
      checkOutput("reload");
      if (md_busy) cnt++;
    end
    chk("reload_busy_len", 32'(cnt), 32'(DIV_L));

    // Randomized traffic against the reference model.
    for (int k = 0; k < 600; k++) begin
      v.rs_d        = 5'($urandom_range(0, 3));
      v.rt_d        = 5'($urandom_range(0, 3));
      v.rs_e        = 5'($urandom_range(0, 3));
      v.rt_e        = 5'($urandom_range(0, 3));
      v.wreg_e      = 5'($urandom_range(0, 3));
      v.wreg_m      = 5'($urandom_range(0, 3));
      v.wreg_w      = 5'($urandom_range(0, 3));
      v.branch_d    = 1'($urandom_range(0, 1));
      v.jump_d      = ($urandom_range(0, 7) == 0);
      v.pc_src_d    = 1'($urandom_range(0, 1));
      v.hilo_use_d  = 1'($urandom_range(0, 1));
      v.regwrite_e  = 1'($urandom_range(0, 1));
      v.memtoreg_e  = 1'($urandom_range(0, 1));
      v.regwrite_m  = 1'($urandom_range(0, 1));
      v.memtoreg_m  = 1'($urandom_range(0, 1));
      v.regwrite_w  = 1'($urandom_range(0, 1));
      v.imem_ready  = ($urandom_range(0, 4) != 0);
      v.md_is_div_e = ($urandom_range(0, 3) == 0);
      v.md_start_e  = !model_busy() && ($urandom_range(0, 5) == 0);
      applyStimulus(v, $urandom_range(0, 63) == 0);
      checkOutput("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage pipeline. It drives the Fetch/Decode instruction register's enable and reset (stall / nop-inject), the PC enable, the Execute flush, and the forwarding selects. It also tracks the multi-cycle multiply/divide unit with an internal FSM and counter, so HI/LO consumers are held in Decode until the result exists. It sits beside the datapath and receives the register numbers and control bits of the D, E, M and W stages.

## Interface
- MULT_LAT, 4: cycles the multiplier is busy after issue (≥1)
- DIV_LAT, 32: cycles the divider is busy after issue (≥1)
- CW, 6: counter width; must satisfy 2^CW > max(MULT_LAT, DIV_LAT)

- ctrl_bus  modport ctrl_bus_if.central  —  ctrl_bus.clk (single clock), ctrl_bus.reset (synchronous, active-high)
- rs_d, rt_d  in  5 each  Decode source registers
- branch_d, jump_d, pc_src_d  in  1 each  Decode branch, jump, branch-taken
- hilo_use_d  in  1  Decode instruction reads HI/LO or starts mult/div (mfhi/mflo/mult/div)
- rs_e, rt_e, wreg_e  in  5 each  Execute sources and destination
- regwrite_e, memtoreg_e  in  1 each
- md_start_e, md_is_div_e  in  1 each  mult/div issuing in E; 1 = div
- wreg_m, wreg_w  in  5 each
- regwrite_m, memtoreg_m, regwrite_w  in  1 each
- imem_ready  in  1  fetch word valid this cycle
- stall_f  out  1  PC hold
- stall_d  out  1  F/D register hold (register enable = ~stall_d)
- flush_d  out  1  F/D register reset to nop
- flush_e  out  1  D/E register clear
- fwd_a_d, fwd_b_d  out  1 each  Decode comparator takes the M-stage result
- fwd_a_e, fwd_b_e  out  2 each  Execute operand select
- md_busy  out  1  mult/div in progress

## Operation
- Forwarding (combinational): fwd_x_e = MEM if regwrite_m & wreg_m≠0 & wreg_m==src_e; otherwise WB if regwrite_w & wreg_w≠0 & match; otherwise RF. M has priority over W. fwd_x_d = regwrite_m & wreg_m≠0 & wreg_m==src_d.
- lw_stall = memtoreg_e & wreg_e≠0 & (wreg_e==rs_d | wreg_e==rt_d).
- br_stall = branch_d & [(regwrite_e & wreg_e≠0 & wreg_e∈{rs_d,rt_d}) | (memtoreg_m & wreg_m≠0 & wreg_m∈{rs_d,rt_d})].
- md_stall = hilo_use_d & (state==MD_BUSY).
- stall = lw_stall | br_stall | md_stall. When stall is set: stall_f=1, stall_d=1, flush_e=1.
- flush_d = (pc_src_d | jump_d | ~imem_ready) & ~stall. stall_d has priority; F/D holds its content.
- ~imem_ready also sets stall_f, so the PC holds and a bubble enters D.
- FSM states: RUN, MD_BUSY.
  - In RUN, md_start_e → MD_BUSY; cnt ← (md_is_div_e ? DIV_LAT : MULT_LAT) − 1.
  - In MD_BUSY: if cnt==0, go to RUN; otherwise cnt−1.
  - md_start_e while in MD_BUSY reloads cnt with the new latency and stays in MD_BUSY. This is a protocol violation, and the bench flags it.
- md_busy = (state==MD_BUSY).

## Timing
- Forwarding and stall/flush outputs are combinational from the inputs and the current state, with no added latency.
- md_start_e sampled at edge N → md_busy=1 for exactly L cycles starting at edge N, low after edge N+L. L is MULT_LAT or DIV_LAT.
- The hilo consumer in D is released in the first cycle where md_busy=0.
- Synchronous reset, sampled on the clk edge: state←RUN, cnt←0.
- While reset is high, all outputs are forced to 0: stall_f, stall_d, flush_d, flush_e, fwd_*, md_busy.
- Reset in the middle of MD_BUSY returns to RUN on that edge.
- All three stall causes at once: the outputs are the same as for any single cause. flush_d stays 0.

## Structure
- Package hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - md_state_t enum: RUN, MD_BUSY
  - NOP_INST = 32'h0000_0020
- Sub-module md_timer: FSM plus down-counter. Inputs are start, is_div and reset; the output is busy. It is parameterised by MULT_LAT, DIV_LAT and CW.
- Forwarding and stall logic live in the top level as always_comb.

## Test plan
- lw $8 in E (wreg_e=8, memtoreg_e=1) with rs_d=8 → stall_f=stall_d=flush_e=1 for 1 cycle. With rs_d=0 and wreg_e=0 → no stall.
- regwrite_m=1, wreg_m=5, regwrite_w=1, wreg_w=5, rs_e=5 → fwd_a_e=FWD_MEM. Drop regwrite_m → FWD_WB.
- pc_src_d=1 with no stall → flush_d=1. Same cycle plus br_stall (regwrite_e, wreg_e=rs_d=3) → flush_d=0, stall_d=1.
- md_start_e=1, md_is_div_e=0 → md_busy high 4 cycles. hilo_use_d held high → stall_d=1 for those 4 cycles, then 0. With div → 32 cycles.
- Reset asserted at cycle 10 of a div → next cycle md_busy=0, state RUN. All outputs 0 while reset is high.
- imem_ready=0 for 3 cycles, no other hazard → stall_f=1, flush_d=1 each cycle. With lw_stall concurrent → flush_d=0, stall_d=1.
